// File: rtl/sss_re_mapper_if.sv
// Frequency-domain sample stream from the SSS mapper
// to the resource-grid writer.
interface sss_re_mapper_if #(
  parameter int IQ_W = 16
);
  logic                   out_valid;
  logic                   out_ready;
  logic signed [IQ_W-1:0] out_i;
  logic signed [IQ_W-1:0] out_q;
  logic [6:0]             out_k;
  logic                   out_last;

  modport master (
    output out_valid,
    output out_i,
    output out_q,
    output out_k,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_i,
    input  out_q,
    input  out_k,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/sss_re_mapper.sv
// Maps a captured 62-bit SSS sequence onto 72 BPSK
// subcarriers (guard, data, guard) over valid/ready.
module sss_re_mapper #(
  parameter int                     IQ_W  = 16,
  parameter logic signed [IQ_W-1:0] AMP   = 16'sd11585,
  parameter int                     GUARD = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [61:0]      sss,
  output logic             start_ready,
  output logic             done,
  sss_re_mapper_if.master  out
);

  typedef enum logic [2:0] {
    IDLE,
    GUARD_LO,
    DATA,
    GUARD_HI,
    DONE
  } state_e;

  localparam logic [6:0] K_LO_END   = 7'(GUARD - 1);
  localparam logic [6:0] K_DATA_END = 7'(GUARD + 61);
  localparam logic [6:0] K_LAST     = 7'(2 * GUARD + 61);

  state_e      state_q, state_d;
  logic [6:0]  k_q, k_d;
  logic [61:0] seq_q, seq_d;
  logic        xfer;
  logic [6:0]  bit_idx;
  logic        bit_v;

  assign xfer = out.out_valid && out.out_ready;

  // First data subcarrier carries seq bit 61.
  assign bit_idx = K_DATA_END - k_q;
  assign bit_v   = |(seq_q & (62'(1) << bit_idx));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      seq_q   <= seq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    seq_d   = seq_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = GUARD_LO;
          k_d     = '0;
          seq_d   = sss;
        end
      end
      GUARD_LO: begin
        if (xfer) begin
          k_d = k_q + 7'd1;
          if (k_q == K_LO_END) state_d = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          k_d = k_q + 7'd1;
          if (k_q == K_DATA_END) state_d = GUARD_HI;
        end
      end
      GUARD_HI: begin
        if (xfer) begin
          if (k_q == K_LAST) state_d = DONE;
          else               k_d = k_q + 7'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_ready   = 1'b0;
    done          = 1'b0;
    out.out_valid = 1'b0;
    out.out_i     = '0;
    out.out_q     = '0;
    out.out_k     = '0;
    out.out_last  = 1'b0;
    unique case (1'b1)
      state_q == IDLE: start_ready = 1'b1;
      state_q == DONE: done = 1'b1;
      state_q == DATA: begin
        out.out_valid = 1'b1;
        out.out_k     = k_q;
        out.out_i     = bit_v ? -AMP : AMP;
      end
      state_q == GUARD_LO: begin
        out.out_valid = 1'b1;
        out.out_k     = k_q;
      end
      state_q == GUARD_HI: begin
        out.out_valid = 1'b1;
        out.out_k     = k_q;
        out.out_last  = (k_q == K_LAST);
      end
      default: ;
    endcase
  end

endmodule
